// File: rtl/fsm_traffic.sv
`timescale 1ns/1ps
// fsm_traffic: Moore traffic-intersection controller with a pedestrian walk
// phase and optional side-sensor green extension.
// Optional feature macro: FSM_TRAFFIC_SENSOR_EXT_EN (sensor extends greens).
module fsm_traffic #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       walk,
  input  logic       sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    WALK   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4
  } state_e;

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_q, sec_d;
  logic          walk_req_q, walk_req_d;
  logic          tick, expire, changing, ext_now;
  logic [3:0]    dur;

  assign tick     = (presc_q == PRESC_MAX);
  assign changing = (state_d != state_q);

`ifdef FSM_TRAFFIC_SENSOR_EXT_EN
  logic ext_q, ext_d;
  logic green;

  assign green = (state_q == MAIN_G) || (state_q == SIDE_G);
  // Including this cycle's sensor lets a sample on the expiry edge still count.
  assign ext_now = ext_q | (sensor & green);

  // Extend flag: latch sensor during a green, drop it whenever the phase ends.
  always_comb begin
    ext_d = ext_now;
    if (changing) ext_d = 1'b0;
  end

  // Extend flag register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) ext_q <= 1'b0;
    else     ext_q <= ext_d;
  end
`else
  logic unused_sensor;
  assign unused_sensor = sensor;
  assign ext_now       = 1'b0;
`endif

  // Phase duration in ticks; greens stretch when the extend flag is set.
  always_comb begin
    dur = 4'd2;
    unique case (state_q)
      MAIN_G:  dur = ext_now ? 4'd9 : 4'd6;
      MAIN_Y:  dur = 4'd2;
      WALK:    dur = 4'd3;
      SIDE_G:  dur = ext_now ? 4'd6 : 4'd3;
      SIDE_Y:  dur = 4'd2;
      default: dur = 4'd2;
    endcase
  end

  assign expire = tick && (sec_q == dur - 4'd1);

  // Next-state: advance only when the current phase's last tick completes.
  always_comb begin
    state_d = state_q;
    if (expire) begin
      unique case (state_q)
        MAIN_G:  state_d = MAIN_Y;
        // A press on this very edge is honoured alongside a latched request.
        MAIN_Y:  state_d = (walk_req_q | walk) ? WALK : SIDE_G;
        WALK:    state_d = SIDE_G;
        SIDE_G:  state_d = SIDE_Y;
        SIDE_Y:  state_d = MAIN_G;
        default: state_d = MAIN_G;
      endcase
    end else if (!(state_q inside {MAIN_G, MAIN_Y, WALK, SIDE_G, SIDE_Y})) begin
      state_d = MAIN_G;
    end
  end

  // Prescaler and phase tick counter restart on every state change so each
  // phase is exactly duration*TICK_DIV cycles.
  always_comb begin
    presc_d = presc_q + PW'(1);
    sec_d   = sec_q;
    if (changing) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      sec_d   = sec_q + 4'd1;
    end
  end

  // Walk request: any press sets it; entering WALK consumes it.
  always_comb begin
    walk_req_d = walk_req_q | walk;
    if (changing && (state_d == WALK)) walk_req_d = 1'b0;
  end

  // State, counters and walk flag registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= MAIN_G;
      presc_q    <= '0;
      sec_q      <= '0;
      walk_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      walk_req_q <= walk_req_d;
    end
  end

  // Lamp decode straight from the state register (no input-to-output path).
  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk_light = 1'b0;
    unique case (state_q)
      MAIN_G: main_light = LAMP_G;
      MAIN_Y: main_light = LAMP_Y;
      WALK:   walk_light = 1'b1;
      SIDE_G: side_light = LAMP_G;
      SIDE_Y: side_light = LAMP_Y;
      default: begin
        main_light = LAMP_R;
        side_light = LAMP_R;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_traffic.sv
`timescale 1ns/1ps
// tb_fsm_traffic: phase-sequence scoreboard for fsm_traffic (TICK_DIV=10).
module tb_fsm_traffic;

  localparam int TD = 10;

  localparam logic [6:0] PH_MG = 7'b001_100_0;
  localparam logic [6:0] PH_MY = 7'b010_100_0;
  localparam logic [6:0] PH_WK = 7'b100_100_1;
  localparam logic [6:0] PH_SG = 7'b100_001_0;
  localparam logic [6:0] PH_SY = 7'b100_010_0;

`ifdef FSM_TRAFFIC_SENSOR_EXT_EN
  localparam int MG_EXT = 9;
  localparam int SG_EXT = 6;
`else
  localparam int MG_EXT = 6;
  localparam int SG_EXT = 3;
`endif

  typedef struct {
    logic [6:0] o;
    int         len;
  } phase_t;

  logic       clock, rst, walk, sensor;
  logic [2:0] main_light, side_light;
  logic       walk_light;
  logic [6:0] outs;

  int n_chk  = 0;
  int n_fail = 0;
  phase_t exp_q[$];

  fsm_traffic #(.TICK_DIV(TD)) dut (
    .clock      (clock),
    .rst        (rst),
    .walk       (walk),
    .sensor     (sensor),
    .main_light (main_light),
    .side_light (side_light),
    .walk_light (walk_light)
  );

  assign outs = {main_light, side_light, walk_light};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [6:0] o, input int ticks);
    phase_t p;
    p.o   = o;
    p.len = ticks * TD;
    exp_q.push_back(p);
  endtask

  // Measure each phase as a run of constant lamps; compare against queue head.
  task automatic drain(input string tag);
    phase_t     e;
    logic [6:0] cur;
    int         n;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      cur = outs;
      n   = 0;
      do begin
        @(negedge clock);
        n++;
      end while (outs == cur && n < 300);
      chk({tag, "_lamps"}, 32'(cur), 32'(e.o));
      chk({tag, "_len"}, n, e.len);
    end
  endtask

  // Hold reset a few cycles, check the reset decode, release on a negedge.
  task automatic do_rst(input logic w, input logic s);
    rst    = 1'b1;
    walk   = w;
    sensor = s;
    repeat (3) @(negedge clock);
    chk("rst_lamps", 32'(outs), 32'(PH_MG));
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; walk = 1'b0; sensor = 1'b0;

    // Idle cycle, no requests.
    do_rst(1'b0, 1'b0);
    push(PH_MG, 6); push(PH_MY, 2); push(PH_SG, 3); push(PH_SY, 2); push(PH_MG, 6);
    drain("idle");

    // Walk held: WALK inserted each cycle round.
    do_rst(1'b1, 1'b0);
    push(PH_MG, 6); push(PH_MY, 2); push(PH_WK, 3); push(PH_SG, 3); push(PH_SY, 2);
    push(PH_MG, 6); push(PH_MY, 2); push(PH_WK, 3);
    drain("hold");
    walk = 1'b0;

    // Sensor held: greens extended only when the feature is built in.
    do_rst(1'b0, 1'b1);
    push(PH_MG, MG_EXT); push(PH_MY, 2); push(PH_SG, SG_EXT); push(PH_SY, 2); push(PH_MG, MG_EXT);
    drain("sens");
    sensor = 1'b0;

    // Async reset mid SIDE_G with a walk pending; the request must be lost.
    do_rst(1'b0, 1'b0);
    push(PH_MG, 6); push(PH_MY, 2);
    drain("pre");
    repeat (5) @(negedge clock);
    walk = 1'b1;
    @(negedge clock);
    walk = 1'b0;
    repeat (5) @(negedge clock);
    chk("sg_before", 32'(outs), 32'(PH_SG));
    #2 rst = 1'b1;
    #1 chk("arst_lamps", 32'(outs), 32'(PH_MG));
    #97;
    @(negedge clock);
    rst = 1'b0;
    push(PH_MG, 6); push(PH_MY, 2); push(PH_SG, 3); push(PH_SY, 2);
    drain("post");

    // One-cycle press during MAIN_G: served once only.
    do_rst(1'b0, 1'b0);
    fork
      begin
        repeat (10) @(negedge clock);
        walk = 1'b1;
        @(negedge clock);
        walk = 1'b0;
      end
    join_none
    push(PH_MG, 6); push(PH_MY, 2); push(PH_WK, 3); push(PH_SG, 3); push(PH_SY, 2);
    push(PH_MG, 6); push(PH_MY, 2); push(PH_SG, 3);
    drain("pulse");

    // Press only on the MAIN_Y expiry edge (edge 80 after release).
    do_rst(1'b0, 1'b0);
    fork
      begin
        repeat (79) @(negedge clock);
        walk = 1'b1;
        @(negedge clock);
        walk = 1'b0;
      end
    join_none
    push(PH_MG, 6); push(PH_MY, 2); push(PH_WK, 3); push(PH_SG, 3);
    drain("edge");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_traffic.md
# fsm_traffic

Moore-style traffic-intersection controller that sequences the main-street and side-street signal heads and a pedestrian walk lamp. It runs from the single system clock and derives a one-second time base internally. A side-street vehicle sensor extends green phases, and a latched pedestrian request inserts an all-red walk phase. It sits between debounced button/sensor inputs and the lamp drivers.

## Interface
- TICK_DIV, default 10: clock cycles per time-base tick (one "second"); must be ≥1. Use 100_000_000 on hardware at 100 MHz.
- clock  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- walk  in  1  pedestrian request, level-sampled every cycle, synchronous.
- sensor  in  1  side-street vehicle present, level-sampled every cycle, synchronous.
- main_light  out  3  main-street head, one-hot {red, yellow, green}: 3'b001 green, 3'b010 yellow, 3'b100 red.
- side_light  out  3  side-street head, same encoding.
- walk_light  out  1  pedestrian walk lamp, 1 = walk.

## Operation
- States: MAIN_G, MAIN_Y, WALK, SIDE_G, SIDE_Y.
- Outputs are a pure decode of the state register:
  - MAIN_G: main 001, side 100, walk_light 0.
  - MAIN_Y: main 010, side 100, walk_light 0.
  - WALK: main 100, side 100, walk_light 1.
  - SIDE_G: main 100, side 001, walk_light 0.
  - SIDE_Y: main 100, side 010, walk_light 0.
- Base durations in ticks: MAIN_G 6, MAIN_Y 2, WALK 3, SIDE_G 3, SIDE_Y 2.
- Transitions:
  - MAIN_G→MAIN_Y.
  - MAIN_Y→WALK if the walk request is pending, else →SIDE_G.
  - WALK→SIDE_G.
  - SIDE_G→SIDE_Y.
  - SIDE_Y→MAIN_G.
- Walk request flag:
  - Set on any cycle with walk=1.
  - Cleared on the cycle the FSM enters WALK.
  - A press during WALK sets it again, so it is served on the next cycle.
- Sensor extension (see Configuration):
  - If sensor=1 on any cycle while in MAIN_G or SIDE_G, an extend flag latches for that phase.
  - Extended phase duration: MAIN_G 9 ticks, SIDE_G 6 ticks.
  - The extend flag clears on every state change.
- The extension decision is evaluated when the base duration expires. If sensor first rises after base expiry, it has no effect, because the state has already advanced.

## Timing
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits a 1-cycle tick on the terminal count.
  - The prescaler and the phase tick counter both reset to 0 on every state change. Each phase therefore lasts exactly duration×TICK_DIV cycles.
- Reset (async, while rst=1):
  - state MAIN_G, main_light 001, side_light 100, walk_light 0.
  - All counters 0; walk and extend flags 0.
- After rst deasserts, MAIN_G holds for 6×TICK_DIV rising edges, then changes.
- Full unextended cycle without walk: 13×TICK_DIV cycles. Add 3×TICK_DIV when walk is served.
- Reset mid-phase: immediate return to MAIN_G. A pending walk request is discarded.
- Simultaneous walk=1 and the MAIN_Y expiry edge: the request counts, so the next state is WALK.
- Inputs are sampled only on rising edges. No combinational path from inputs to outputs.

## Configuration
- Macro FSM_TRAFFIC_SENSOR_EXT_EN.
  - Defined: sensor extension is active as described.
  - Undefined: sensor is ignored, the extend flag is tied to 0, and the green phases always use base durations.

## Test plan
- Reset, no inputs, TICK_DIV=10: main 001 for 60 cycles → MAIN_Y 20 → SIDE_G 30 → SIDE_Y 20 → MAIN_G. walk_light stays 0.
- walk=1 held from reset release: after MAIN_Y, WALK for 30 cycles with main/side 100 and walk_light 1. Then SIDE_G. Walk is re-served every cycle while walk is held.
- sensor=1 from reset release, macro defined: MAIN_G lasts 90 cycles and SIDE_G lasts 60 cycles. Macro undefined: 60 and 30.
- rst pulsed 100 ns in the middle of SIDE_G with walk pending: outputs go to main 001, side 100, walk 0 asynchronously. The next MAIN_Y goes to SIDE_G, not WALK.
- Short walk pulse (1 cycle) during MAIN_G: request latched, WALK served once, then not again without a new press.
- walk asserted on the same edge MAIN_Y expires: the next state is WALK.
